any1_bf_issue_queue: RTL and testbench

- Issue buffer and result stage wrapped around the combinational bitfield unit (BFSET/BFCLR/BFCHG/BFINS/BFEXT/BFEXTU/BFFFO).
- Holds up to QDEPTH bitfield instructions and captures missing operands from the common data bus (CDB).
- Each cycle it dispatches at most one oldest-ready entry into the bitfield unit and registers the result for the writeback arbiter.

---
 rtl/any1_pkg.sv | 46 ++++
 rtl/any1_bf_iq_select.sv | 25 ++
 rtl/any1_bf_issue_queue.sv | 163 ++++++++++++++++
 tb/tb_any1_bf_issue_queue.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/any1_pkg.sv
// Shared types for the any1 bitfield issue queue: op encodings, operand and entry records.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package any1_pkg;

    localparam int BF_DWIDTH = 64;
    localparam int BF_TAGW   = 5;

    typedef enum logic [2:0] {
        BFSET  = 3'd0,
        BFCLR  = 3'd1,
        BFCHG  = 3'd2,
        BFINS  = 3'd3,
        BFEXT  = 3'd4,
        BFEXTU = 3'd5,
        BFFFO  = 3'd6
    } bf_op_e;

    typedef struct packed {
        logic [BF_DWIDTH-1:0] value;
        logic                 rdy;
        logic [BF_TAGW-1:0]   tag;
    } bf_operand_t;

    // opnd[0..3] hold operands a, b, c, d
    typedef struct packed {
        logic                  valid;
        logic [63:0]           inst;
        logic [BF_TAGW-1:0]    rtag;
        bf_operand_t [3:0]     opnd;
    } bf_iq_entry_t;

    // Latch a CDB broadcast into an operand that is still waiting on that tag.
    function automatic bf_operand_t bf_capture(input bf_operand_t o, input logic cdb_v,
                                               input logic [BF_TAGW-1:0] cdb_tag,
                                               input logic [BF_DWIDTH-1:0] cdb_res);
        bf_operand_t r;
        r = o;
        if (!o.rdy && cdb_v && (o.tag == cdb_tag)) begin
            r.value = cdb_res;
            r.rdy   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/any1_bf_iq_select.sv
// Priority encoder: lowest-index asserted request wins.
// Latency: combinational.
// Backpressure: none; found=0 when no request is asserted.
module any1_bf_iq_select #(
    parameter int QDEPTH = 4,
    parameter int IW     = $clog2(QDEPTH)
) (
    input  logic [QDEPTH-1:0] req,
    output logic [IW-1:0]     idx,
    output logic              found
);

    // Scan from the top down so the lowest ready index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = QDEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = i[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/any1_bf_issue_queue.sv
// Collapsing issue queue + result register around the external bitfield unit.
// Latency: enqueue edge then dispatch edge; result valid two edges after a ready enqueue.
// Backpressure: enq_rdy_o = count<QDEPTH; result held until res_ack_i, dispatch stalls meanwhile.
module any1_bf_issue_queue
    import any1_pkg::*;
#(
    parameter int DWIDTH = BF_DWIDTH,
    parameter int QDEPTH = 4,
    parameter int TAGW   = BF_TAGW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              enq_v_i,
    output logic              enq_rdy_o,
    input  logic [63:0]       enq_inst_i,
    input  logic [TAGW-1:0]   enq_rtag_i,
    input  logic [DWIDTH-1:0] enq_a_i,
    input  logic [DWIDTH-1:0] enq_b_i,
    input  logic [DWIDTH-1:0] enq_c_i,
    input  logic [DWIDTH-1:0] enq_d_i,
    input  logic              enq_av_i,
    input  logic              enq_bv_i,
    input  logic              enq_cv_i,
    input  logic              enq_dv_i,
    input  logic [TAGW-1:0]   enq_at_i,
    input  logic [TAGW-1:0]   enq_bt_i,
    input  logic [TAGW-1:0]   enq_ct_i,
    input  logic [TAGW-1:0]   enq_dt_i,
    input  logic              cdb_v_i,
    input  logic [TAGW-1:0]   cdb_tag_i,
    input  logic [DWIDTH-1:0] cdb_res_i,
    output logic [63:0]       bf_inst_o,
    output logic [DWIDTH-1:0] bf_a_o,
    output logic [DWIDTH-1:0] bf_b_o,
    output logic [DWIDTH-1:0] bf_c_o,
    output logic [DWIDTH-1:0] bf_d_o,
    input  logic [DWIDTH-1:0] bf_res_i,
    output logic              res_v_o,
    output logic [TAGW-1:0]   res_tag_o,
    output logic [DWIDTH-1:0] res_o,
    input  logic              res_ack_i
);

    localparam int IW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    bf_iq_entry_t      q     [QDEPTH];
    bf_iq_entry_t      q_nxt [QDEPTH];
    bf_iq_entry_t      ext   [QDEPTH+1];
    bf_iq_entry_t      enq_entry;
    bf_iq_entry_t      drv;
    logic [CW-1:0]     count;
    logic [CW-1:0]     enq_idx;
    logic [QDEPTH-1:0] req;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     sel_idx;
    logic              found;
    logic              can_issue;
    logic              dispatch;
    logic              enq_fire;

    // Deliberately ignores same-cycle frees so the ready path stays a pure register compare.
    assign enq_rdy_o = (count < CW'(QDEPTH));
    assign enq_fire  = enq_v_i & enq_rdy_o;
    assign can_issue = ~res_v_o | res_ack_i;
    assign dispatch  = can_issue & found;
    // Shift-down on dispatch means the new entry lands one slot lower.
    assign enq_idx   = count - CW'(dispatch);

    // An entry is a candidate once all four operands are ready.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            req[i] = q[i].valid & q[i].opnd[0].rdy & q[i].opnd[1].rdy
                     & q[i].opnd[2].rdy & q[i].opnd[3].rdy;
        end
    end

    any1_bf_iq_select #(.QDEPTH(QDEPTH), .IW(IW)) u_select (
        .req   (req),
        .idx   (idx),
        .found (found)
    );

    // Feed the bitfield unit: selected entry, else entry 0, else zeros when empty.
    always_comb begin
        sel_idx = dispatch ? idx : '0;
        drv     = q[sel_idx];
        if (!drv.valid) begin
            drv = '0;
        end
        bf_inst_o = drv.inst;
        bf_a_o    = drv.opnd[0].value;
        bf_b_o    = drv.opnd[1].value;
        bf_c_o    = drv.opnd[2].value;
        bf_d_o    = drv.opnd[3].value;
    end

    // Build the incoming entry, snooping a CDB broadcast in the same cycle.
    always_comb begin
        enq_entry       = '0;
        enq_entry.valid = 1'b1;
        enq_entry.inst  = enq_inst_i;
        enq_entry.rtag  = enq_rtag_i;
        enq_entry.opnd[0] = bf_capture('{value: enq_a_i, rdy: enq_av_i, tag: enq_at_i},
                                       cdb_v_i, cdb_tag_i, cdb_res_i);
        enq_entry.opnd[1] = bf_capture('{value: enq_b_i, rdy: enq_bv_i, tag: enq_bt_i},
                                       cdb_v_i, cdb_tag_i, cdb_res_i);
        enq_entry.opnd[2] = bf_capture('{value: enq_c_i, rdy: enq_cv_i, tag: enq_ct_i},
                                       cdb_v_i, cdb_tag_i, cdb_res_i);
        enq_entry.opnd[3] = bf_capture('{value: enq_d_i, rdy: enq_dv_i, tag: enq_dt_i},
                                       cdb_v_i, cdb_tag_i, cdb_res_i);
    end

    // Next queue image: collapse over the dispatched slot, wake up, then append.
    always_comb begin
        ext[QDEPTH] = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            ext[i] = q[i];
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (dispatch && (i >= int'(sel_idx))) begin
                q_nxt[i] = ext[i+1];
            end else begin
                q_nxt[i] = ext[i];
            end
            if (q_nxt[i].valid) begin
                for (int k = 0; k < 4; k++) begin
                    q_nxt[i].opnd[k] = bf_capture(q_nxt[i].opnd[k], cdb_v_i, cdb_tag_i, cdb_res_i);
                end
            end
            if (enq_fire && (i == int'(enq_idx))) begin
                q_nxt[i] = enq_entry;
            end
        end
    end

    // State update; reset and flush both empty the queue and drop any pending result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
            count     <= '0;
            res_v_o   <= 1'b0;
            res_tag_o <= '0;
            res_o     <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
            count   <= '0;
            res_v_o <= 1'b0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) q[i] <= q_nxt[i];
            count <= count - CW'(dispatch) + CW'(enq_fire);
            if (dispatch) begin
                res_v_o   <= 1'b1;
                res_o     <= bf_res_i;
                res_tag_o <= q[sel_idx].rtag;
            end else if (res_ack_i) begin
                res_v_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_any1_bf_issue_queue.sv
module tb_any1_bf_issue_queue;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        enq_v = 1'b0;
    logic        enq_rdy;
    logic [63:0] enq_inst = '0;
    logic [4:0]  enq_rtag = '0;
    logic [63:0] eop [4];
    logic        eov [4];
    logic [4:0]  eot [4];
    logic        cdb_v = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [63:0] cdb_res = '0;
    logic [63:0] bf_inst, bf_a, bf_b, bf_c, bf_d, bf_res;
    logic        res_v;
    logic [4:0]  res_tag;
    logic [63:0] res;
    logic        res_ack = 1'b0;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [63:0]      inst;
        logic [4:0]       rtag;
        logic [3:0][63:0] v;
        logic [3:0]       r;
        logic [3:0][4:0]  t;
    } ment_t;
    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] val;
    } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    bit    mres_v = 1'b0;

    always #5 clk = ~clk;

    any1_bf_issue_queue dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .enq_v_i(enq_v), .enq_rdy_o(enq_rdy), .enq_inst_i(enq_inst), .enq_rtag_i(enq_rtag),
        .enq_a_i(eop[0]), .enq_b_i(eop[1]), .enq_c_i(eop[2]), .enq_d_i(eop[3]),
        .enq_av_i(eov[0]), .enq_bv_i(eov[1]), .enq_cv_i(eov[2]), .enq_dv_i(eov[3]),
        .enq_at_i(eot[0]), .enq_bt_i(eot[1]), .enq_ct_i(eot[2]), .enq_dt_i(eot[3]),
        .cdb_v_i(cdb_v), .cdb_tag_i(cdb_tag), .cdb_res_i(cdb_res),
        .bf_inst_o(bf_inst), .bf_a_o(bf_a), .bf_b_o(bf_b), .bf_c_o(bf_c), .bf_d_o(bf_d),
        .bf_res_i(bf_res),
        .res_v_o(res_v), .res_tag_o(res_tag), .res_o(res), .res_ack_i(res_ack)
    );

    // Behavioural bitfield unit: field is bits c .. c+d (clamped at bit 63).
    function automatic logic [63:0] bfm(input logic [63:0] inst, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] c,
                                        input logic [63:0] d);
        int lo, wf;
        logic [63:0] m, f, lowm, r;
        lo = int'(c[5:0]);
        wf = int'(d[5:0]) + 1;
        if (lo + wf > 64) wf = 64 - lo;
        lowm = (64'd1 << wf) - 64'd1;
        m = lowm << lo;
        f = (a >> lo) & lowm;
        case (inst[63:61])
            3'd0: r = a | m;
            3'd1: r = a & ~m;
            3'd2: r = a ^ m;
            3'd3: r = (a & ~m) | ((b << lo) & m);
            3'd4: r = f[wf-1] ? (f | ~lowm) : f;
            3'd5: r = f;
            3'd6: begin
                r = '1;
                for (int i = 63; i >= 0; i--) if (i < wf && f[i]) r = 64'(i);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    assign bf_res = bfm(bf_inst, bf_a, bf_b, bf_c, bf_d);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Reference model: advance one clock using the inputs currently applied.
    task automatic model_step();
        ment_t e;
        int    sel;
        bit    can;
        bit    rdy_in;
        rdy_in = (mq.size() < QD);
        if (rst || flush) begin
            mq.delete();
            mres_v = 1'b0;
            return;
        end
        can = !mres_v || res_ack;
        sel = -1;
        foreach (mq[i]) if (sel < 0 && (&mq[i].r)) sel = i;
        if (can && sel >= 0) begin
            e = mq[sel];
            exp_q.push_back({e.rtag, bfm(e.inst, e.v[0], e.v[1], e.v[2], e.v[3])});
            mq.delete(sel);
            mres_v = 1'b1;
        end else if (res_ack) begin
            mres_v = 1'b0;
        end
        foreach (mq[i]) begin
            e = mq[i];
            for (int k = 0; k < 4; k++) begin
                if (!e.r[k] && cdb_v && e.t[k] == cdb_tag) begin
                    e.v[k] = cdb_res;
                    e.r[k] = 1'b1;
                end
            end
            mq[i] = e;
        end
        if (enq_v && rdy_in) begin
            e.inst = enq_inst;
            e.rtag = enq_rtag;
            for (int k = 0; k < 4; k++) begin
                e.t[k] = eot[k];
                e.r[k] = eov[k] || (cdb_v && eot[k] == cdb_tag);
                e.v[k] = (!eov[k] && cdb_v && eot[k] == cdb_tag) ? cdb_res : eop[k];
            end
            mq.push_back(e);
        end
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic tick();
        #1;
        model_step();
        @(negedge clk);
        check("enq_rdy", {63'd0, enq_rdy}, {63'd0, mq.size() < QD});
        check("res_v", {63'd0, res_v}, {63'd0, mres_v});
    endtask

    task automatic set_enq(input logic [2:0] op, input logic [4:0] rtag, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c, input logic [63:0] d,
                           input logic [3:0] vmask, input logic [4:0] wtag);
        enq_v    = 1'b1;
        enq_inst = {op, 61'd0};
        enq_rtag = rtag;
        eop[0] = a; eop[1] = b; eop[2] = c; eop[3] = d;
        for (int k = 0; k < 4; k++) begin
            eov[k] = vmask[k];
            eot[k] = wtag;
        end
    endtask

    // Monitor: each newly presented result must be the oldest expected one; held results stay stable.
    initial begin : monitor
        bit          prev_v = 1'b0;
        logic [63:0] held_res = '0;
        logic [4:0]  held_tag = '0;
        exp_t        x;
        forever begin
            @(posedge clk);
            #1;
            if (res_v && (!prev_v || res_ack)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: tag %h value %h with none outstanding", res_tag, res);
                end else begin
                    x = exp_q.pop_front();
                    check("res_tag", {59'd0, res_tag}, {59'd0, x.tag});
                    check("res_val", res, x.val);
                end
            end else if (res_v) begin
                check("hold_val", res, held_res);
                check("hold_tag", {59'd0, res_tag}, {59'd0, held_tag});
            end
            prev_v   = res_v;
            held_res = res;
            held_tag = res_tag;
        end
    end

    initial begin : driver
        for (int k = 0; k < 4; k++) begin
            eop[k] = '0; eov[k] = 1'b0; eot[k] = '0;
        end
        @(negedge clk);
        tick(); tick();
        check("rst_res_v", {63'd0, res_v}, 64'd0);
        check("rst_res", res, 64'd0);
        check("rst_res_tag", {59'd0, res_tag}, 64'd0);
        check("rst_enq_rdy", {63'd0, enq_rdy}, 64'd1);
        rst = 1'b0;
        res_ack = 1'b1;

        // BFSET with all operands valid
        set_enq(3'd0, 5'd3, 64'd0, 64'd0, 64'd4, 64'd3, 4'hF, 5'd0);
        tick();
        enq_v = 1'b0;
        tick();
        check("bfset_v", {63'd0, res_v}, 64'd1);
        check("bfset_res", res, 64'h00000000000000F0);
        check("bfset_tag", {59'd0, res_tag}, 64'd3);
        tick(); tick();

        // BFCLR waiting on tag 5 for operand a
        set_enq(3'd1, 5'd7, 64'hFFFF, 64'd0, 64'd0, 64'd7, 4'b1110, 5'd5);
        tick();
        enq_v = 1'b0;
        tick(); tick(); tick();
        check("bfclr_blocked", {63'd0, res_v}, 64'd0);
        cdb_v = 1'b1; cdb_tag = 5'd5; cdb_res = 64'hFFFF;
        tick();
        cdb_v = 1'b0;
        tick();
        check("bfclr_res", res, 64'h000000000000FF00);
        check("bfclr_tag", {59'd0, res_tag}, 64'd7);
        tick(); tick();

        // Fill with four blocked entries, then try a fifth
        for (int i = 0; i < 4; i++) begin
            set_enq(3'd2, 5'(20 + i), 64'(i), 64'd0, 64'(i), 64'd1, 4'b1110, 5'(10 + i));
            tick();
        end
        set_enq(3'd2, 5'd30, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 5'd0);
        check("full_rdy", {63'd0, enq_rdy}, 64'd0);
        tick();
        enq_v = 1'b0;
        cdb_v = 1'b1; cdb_tag = 5'd12; cdb_res = 64'h00F0;
        tick();
        cdb_v = 1'b0;
        tick();
        check("bypass_tag", {59'd0, res_tag}, 64'd22);
        foreach (eot[k]) begin end
        cdb_v = 1'b1; cdb_tag = 5'd13; cdb_res = 64'h1234; tick();
        cdb_tag = 5'd10; cdb_res = 64'h5555; tick();
        cdb_tag = 5'd11; cdb_res = 64'hAAAA; tick();
        cdb_v = 1'b0;
        tick(); tick(); tick();

        // Two ready entries with the output held
        res_ack = 1'b0;
        set_enq(3'd5, 5'd1, 64'hABCD, 64'd0, 64'd4, 64'd7, 4'hF, 5'd0); tick();
        set_enq(3'd4, 5'd2, 64'h00F0, 64'd0, 64'd4, 64'd3, 4'hF, 5'd0); tick();
        enq_v = 1'b0;
        tick(); tick(); tick();
        check("held_tag1", {59'd0, res_tag}, 64'd1);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("b2b_v", {63'd0, res_v}, 64'd1);
        check("b2b_tag", {59'd0, res_tag}, 64'd2);
        tick();
        res_ack = 1'b1;
        tick(); tick();

        // Enqueue captures a same-cycle CDB broadcast
        set_enq(3'd3, 5'd4, 64'hFFFF_0000, 64'h0, 64'd8, 64'd7, 4'b1101, 5'd9);
        cdb_v = 1'b1; cdb_tag = 5'd9; cdb_res = 64'h5A;
        tick();
        enq_v = 1'b0; cdb_v = 1'b0;
        tick();
        check("snoop_v", {63'd0, res_v}, 64'd1);
        check("snoop_res", res, 64'hFFFF_5A00);
        tick(); tick();

        // Flush with a pending result, a queued entry and a simultaneous enqueue
        res_ack = 1'b0;
        set_enq(3'd0, 5'd15, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 5'd0); tick();
        set_enq(3'd0, 5'd16, 64'd0, 64'd0, 64'd0, 64'd0, 4'b1110, 5'd25); tick();
        enq_v = 1'b0;
        tick();
        flush = 1'b1;
        set_enq(3'd0, 5'd17, 64'd0, 64'd0, 64'd1, 64'd1, 4'hF, 5'd0);
        tick();
        flush = 1'b0; enq_v = 1'b0; res_ack = 1'b1;
        check("flush_v", {63'd0, res_v}, 64'd0);
        check("flush_rdy", {63'd0, enq_rdy}, 64'd1);
        cdb_v = 1'b1; cdb_tag = 5'd25;
        repeat (5) tick();
        cdb_v = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            enq_v    = $urandom_range(0, 1) == 1;
            enq_inst = {$urandom(), $urandom()};
            enq_rtag = 5'($urandom_range(0, 31));
            for (int k = 0; k < 4; k++) begin
                eop[k] = {$urandom(), $urandom()};
                eov[k] = $urandom_range(0, 2) != 0;
                eot[k] = 5'($urandom_range(0, 7));
            end
            cdb_v   = $urandom_range(0, 1) == 1;
            cdb_tag = 5'($urandom_range(0, 7));
            cdb_res = {$urandom(), $urandom()};
            res_ack = $urandom_range(0, 3) != 0;
            flush   = $urandom_range(0, 99) == 0;
            rst     = $urandom_range(0, 499) == 0;
            tick();
        end

        // Drain: broadcast every tag in use until the queue empties
        enq_v = 1'b0; flush = 1'b0; rst = 1'b0; res_ack = 1'b1;
        for (int n = 0; n < 64; n++) begin
            cdb_v = 1'b1; cdb_tag = 5'(n % 8);
            tick();
        end
        cdb_v = 1'b0;
        repeat (3) tick();
        check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
        check("drain_model_empty", 64'(mq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
